poly_voice_alloc: RTL and testbench

//   Dynamic polyphonic voice allocator; successor to the fixed channel==voice mapping in the synth top.

---
 rtl/poly_voice_alloc_pkg.sv | 25 ++
 rtl/poly_voice_alloc_prio_enc.sv | 25 ++
 rtl/poly_voice_alloc.sv | 147 ++++++++++++++
 tb/tb_poly_voice_alloc.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/poly_voice_alloc_pkg.sv
// rtl/poly_voice_alloc_pkg.sv - shared types, limits and popcount helper for the voice allocator
package poly_voice_alloc_pkg;

    localparam int MAX_VOICES = 16;
    localparam int POP_BW     = $clog2(MAX_VOICES + 1);

    typedef enum logic [2:0] {
        EV_NONE,
        EV_ALLOC,
        EV_RETRIG,
        EV_STEAL,
        EV_DROP,
        EV_OFF
    } voice_ev_e;

    function automatic logic [POP_BW-1:0] bitcount(input logic [MAX_VOICES-1:0] vec);
        logic [POP_BW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_VOICES; i++) begin
            cnt = cnt + POP_BW'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/poly_voice_alloc_prio_enc.sv
// rtl/poly_voice_alloc_prio_enc.sv - combinational lowest-set-bit finder (found flag + index)
module poly_voice_alloc_prio_enc
    import poly_voice_alloc_pkg::*;
#(
    parameter int W = 8,
    localparam int IDX_BW = $clog2(W)
) (
    input  logic [W-1:0]      i_req,
    output logic              o_found,
    output logic [IDX_BW-1:0] o_idx
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_BW'(i);
            end
        end
    end

endmodule

// File: rtl/poly_voice_alloc.sv
// rtl/poly_voice_alloc.sv - dynamic polyphonic voice allocator with age ranks
// Optional feature: VOICE_STEAL_EN (steal the oldest voice instead of dropping when all are busy).
module poly_voice_alloc
    import poly_voice_alloc_pkg::*;
#(
    parameter int VOICES  = 8,
    parameter int NOTE_BW = 7,
    localparam int CNT_BW  = $clog2(VOICES + 1),
    localparam int RANK_BW = $clog2(VOICES)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NOTE_BW-1:0]        note_i,
    input  logic                      noteOnStrb_i,
    input  logic                      noteOffStrb_i,
    output logic [VOICES*NOTE_BW-1:0] voiceNote_o,
    output logic [VOICES-1:0]         voiceGate_o,
    output logic [VOICES-1:0]         voiceTrig_o,
    output logic [CNT_BW-1:0]         activeCnt_o,
    output logic                      dropStrb_o
);

    logic [NOTE_BW-1:0] r_note [VOICES];
    logic [RANK_BW-1:0] r_rank [VOICES];
    logic [VOICES-1:0]  r_gate;
    logic [VOICES-1:0]  r_trig;
    logic [CNT_BW-1:0]  r_cnt;
    logic               r_drop;

    logic               w_free_found;
    logic [RANK_BW-1:0] w_free_idx;
    logic               w_hit;
    logic [RANK_BW-1:0] w_hit_idx;
    logic [VOICES-1:0]  w_off_mask;
    voice_ev_e          w_ev;
    logic [RANK_BW-1:0] w_idx;
    logic               w_start;
    logic [VOICES-1:0]  w_gate_nxt;
    logic [CNT_BW-1:0]  w_cnt_nxt;

    poly_voice_alloc_prio_enc #(.W(VOICES)) u_prio_enc (
        .i_req   (~r_gate),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    // Retrigger lookup only considers sounding voices; note-off mask looks at every voice.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_off_mask = '0;
        for (int v = VOICES - 1; v >= 0; v--) begin
            w_off_mask[v] = (r_note[v] == note_i);
            if (r_gate[v] && (r_note[v] == note_i)) begin
                w_hit     = 1'b1;
                w_hit_idx = RANK_BW'(v);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [RANK_BW-1:0] w_old_idx;

    always_comb begin
        w_old_idx = '0;
        for (int v = 0; v < VOICES; v++) begin
            if (r_rank[v] == RANK_BW'(VOICES - 1)) begin
                w_old_idx = RANK_BW'(v);
            end
        end
    end
`endif

    // Note-on takes precedence over a simultaneous note-off.
    always_comb begin
        w_ev  = EV_NONE;
        w_idx = '0;
        if (noteOnStrb_i) begin
            if (w_hit) begin
                w_ev  = EV_RETRIG;
                w_idx = w_hit_idx;
            end else if (w_free_found) begin
                w_ev  = EV_ALLOC;
                w_idx = w_free_idx;
            end else begin
`ifdef VOICE_STEAL_EN
                w_ev  = EV_STEAL;
                w_idx = w_old_idx;
`else
                w_ev  = EV_DROP;
`endif
            end
        end else if (noteOffStrb_i) begin
            w_ev = EV_OFF;
        end
    end

    always_comb begin
        w_start    = (w_ev == EV_ALLOC) || (w_ev == EV_RETRIG) || (w_ev == EV_STEAL);
        w_gate_nxt = r_gate;
        if (w_start) begin
            w_gate_nxt[w_idx] = 1'b1;
        end else if (w_ev == EV_OFF) begin
            w_gate_nxt = r_gate & ~w_off_mask;
        end
        w_cnt_nxt = CNT_BW'(bitcount(MAX_VOICES'(w_gate_nxt)));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int v = 0; v < VOICES; v++) begin
                r_note[v] <= '0;
                r_rank[v] <= RANK_BW'(v);
            end
            r_gate <= '0;
            r_trig <= '0;
            r_cnt  <= '0;
            r_drop <= 1'b0;
        end else begin
            r_gate <= w_gate_nxt;
            r_cnt  <= w_cnt_nxt;
            r_trig <= '0;
            r_drop <= (w_ev == EV_DROP);
            if (w_start) begin
                r_trig[w_idx] <= 1'b1;
                r_note[w_idx] <= note_i;
                // Everything younger than the started voice ages by one; it becomes newest.
                for (int v = 0; v < VOICES; v++) begin
                    if (r_rank[v] < r_rank[w_idx]) begin
                        r_rank[v] <= r_rank[v] + RANK_BW'(1);
                    end
                end
                r_rank[w_idx] <= '0;
            end
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_note_out
        assign voiceNote_o[g*NOTE_BW +: NOTE_BW] = r_note[g];
    end

    assign voiceGate_o = r_gate;
    assign voiceTrig_o = r_trig;
    assign activeCnt_o = r_cnt;
    assign dropStrb_o  = r_drop;

endmodule

// File: tb/tb_poly_voice_alloc.sv
// tb/tb_poly_voice_alloc.sv - randomized bench with a timestamp-based voice model for poly_voice_alloc
module tb_poly_voice_alloc;

    localparam int V  = 8;
    localparam int NB = 7;
    localparam int CB = $clog2(V + 1);

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic [NB-1:0]   note_i = '0;
    logic            noteOnStrb_i = 1'b0;
    logic            noteOffStrb_i = 1'b0;
    logic [V*NB-1:0] voiceNote_o;
    logic [V-1:0]    voiceGate_o;
    logic [V-1:0]    voiceTrig_o;
    logic [CB-1:0]   activeCnt_o;
    logic            dropStrb_o;

    poly_voice_alloc #(.VOICES(V), .NOTE_BW(NB)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .note_i        (note_i),
        .noteOnStrb_i  (noteOnStrb_i),
        .noteOffStrb_i (noteOffStrb_i),
        .voiceNote_o   (voiceNote_o),
        .voiceGate_o   (voiceGate_o),
        .voiceTrig_o   (voiceTrig_o),
        .activeCnt_o   (activeCnt_o),
        .dropStrb_o    (dropStrb_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: each voice remembers when it was last started; the oldest is the smallest stamp.
    logic [NB-1:0] m_note [V];
    int            m_stamp [V];
    logic [V-1:0]  m_gate;
    logic [V-1:0]  m_trig;
    logic          m_drop;
    int            m_time;

    int  n_vec  = 0;
    int  n_miss = 0;
    bit  chk_en = 0;
    int  cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic m_start(input int v, input logic [NB-1:0] n);
        m_note[v]  = n;
        m_gate[v]  = 1'b1;
        m_trig[v]  = 1'b1;
        m_time++;
        m_stamp[v] = m_time;
    endtask

    task automatic model_step(input logic rst, input logic on, input logic off, input logic [NB-1:0] n);
        int hit, free, old;
        if (rst) begin
            for (int v = 0; v < V; v++) begin
                m_note[v]  = '0;
                m_stamp[v] = -v;
            end
            m_gate = '0;
            m_trig = '0;
            m_drop = 1'b0;
            m_time = 0;
            return;
        end
        m_trig = '0;
        m_drop = 1'b0;
        if (on) begin
            hit = -1;
            free = -1;
            for (int v = 0; v < V; v++) if (m_gate[v] && m_note[v] == n) hit = v;
            for (int v = V - 1; v >= 0; v--) if (!m_gate[v]) free = v;
            if (hit >= 0) m_start(hit, n);
            else if (free >= 0) m_start(free, n);
            else begin
`ifdef VOICE_STEAL_EN
                old = 0;
                for (int v = 1; v < V; v++) if (m_stamp[v] < m_stamp[old]) old = v;
                m_start(old, n);
`else
                old = 0;
                m_drop = 1'b1;
`endif
            end
        end else if (off) begin
            for (int v = 0; v < V; v++) if (m_note[v] == n) m_gate[v] = 1'b0;
        end
    endtask

    task automatic tick(input logic rst, input logic on, input logic off, input logic [NB-1:0] n);
        @(negedge clk_i);
        rst_i = rst;
        noteOnStrb_i = on;
        noteOffStrb_i = off;
        note_i = n;
        @(posedge clk_i);
        model_step(rst, on, off, n);
        cyc++;
        #1;
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            for (int v = 0; v < V; v++) begin
                check($sformatf("note%0d", v), 32'(voiceNote_o[v*NB +: NB]), 32'(m_note[v]));
            end
            check("gate", 32'(voiceGate_o), 32'(m_gate));
            check("trig", 32'(voiceTrig_o), 32'(m_trig));
            check("cnt", 32'(activeCnt_o), 32'($countones(m_gate)));
            check("drop", 32'(dropStrb_o), 32'(m_drop));
        end
    end

    initial begin
        logic r, on, off;
        logic [NB-1:0] n;

        tick(1, 0, 0, 0);
        chk_en = 1;
        tick(1, 1, 0, 9);
        check("rst gate", 32'(voiceGate_o), 0);
        check("rst cnt", 32'(activeCnt_o), 0);
        check("rst trig", 32'(voiceTrig_o), 0);

        tick(0, 1, 0, 60);
        check("t1 note0", 32'(voiceNote_o[0 +: NB]), 60);
        check("t1 gate", 32'(voiceGate_o), 32'h01);
        check("t1 trig", 32'(voiceTrig_o), 32'h01);
        check("t1 cnt", 32'(activeCnt_o), 1);
        tick(0, 0, 0, 0);
        check("t1 trig pulse", 32'(voiceTrig_o), 0);

        tick(0, 1, 0, 64);
        tick(0, 1, 0, 67);
        tick(0, 0, 1, 64);
        check("t2 gate", 32'(voiceGate_o), 32'h05);
        check("t2 note1 kept", 32'(voiceNote_o[NB +: NB]), 64);
        tick(0, 1, 0, 72);
        check("t2 realloc gate", 32'(voiceGate_o), 32'h07);
        check("t2 note1", 32'(voiceNote_o[NB +: NB]), 72);

        tick(0, 1, 0, 60);
        check("t3 trig", 32'(voiceTrig_o), 32'h01);
        check("t3 gate", 32'(voiceGate_o), 32'h07);
        check("t3 cnt", 32'(activeCnt_o), 3);

        for (int i = 0; i < 5; i++) tick(0, 1, 0, NB'(40 + i));
        check("full gate", 32'(voiceGate_o), 32'hFF);
        tick(0, 1, 0, 90);
`ifdef VOICE_STEAL_EN
        check("steal note2", 32'(voiceNote_o[2*NB +: NB]), 90);
        check("steal trig", 32'(voiceTrig_o), 32'h04);
        check("steal drop", 32'(dropStrb_o), 0);
`else
        check("drop strobe", 32'(dropStrb_o), 1);
        check("drop trig", 32'(voiceTrig_o), 0);
        check("drop note2", 32'(voiceNote_o[2*NB +: NB]), 67);
`endif
        check("full cnt", 32'(activeCnt_o), 8);
        tick(0, 0, 0, 0);
        check("drop pulse", 32'(dropStrb_o), 0);

        tick(1, 0, 0, 0);
        tick(0, 1, 1, 50);
        check("t6 gate", 32'(voiceGate_o), 32'h01);
        check("t6 note0", 32'(voiceNote_o[0 +: NB]), 50);
        tick(0, 1, 0, 51);
        tick(1, 1, 0, 52);
        check("t6 rst gate", 32'(voiceGate_o), 0);
        check("t6 rst notes", 32'(|voiceNote_o), 0);
        check("t6 rst cnt", 32'(activeCnt_o), 0);

        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            on  = ($urandom_range(0, 99) < 50);
            off = ($urandom_range(0, 99) < 40);
            n   = NB'(40 + $urandom_range(0, 13));
            tick(r, on, off, n);
        end

        @(negedge clk_i);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
